add_pipe: RTL and testbench



---
 rtl/add_pipe_pkg.sv | 16 +
 rtl/add_pipe_stage.sv | 53 +++++
 rtl/add_pipe.sv | 85 ++++++++
 tb/tb_add_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared types and helpers for the pipelined adder.
// Holds the chunk-width helper and the per-stage control bundle.
package add_pipe_pkg;

    // Width of one carry chunk; a zero stage count is caught by the
    // instantiating module, so fall back to 1 to keep elaboration sane.
    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : 1;
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;
    } ctl_t;

endpackage

// File: rtl/add_pipe_stage.sv
// add_pipe_stage: one CHUNK-bit ripple add plus its enable-gated register.
// Chunk K of the operands is summed and merged into the partial sum.
module add_pipe_stage #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             vin,
    input  logic             cin,
    input  logic [WIDTH-1:0] psum_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic             vout,
    output logic             cout,
    output logic [WIDTH-1:0] psum_o,
    output logic [WIDTH-1:0] opa_o,
    output logic [WIDTH-1:0] opb_o
);

    // Operand bits above this chunk are still needed downstream.
    localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} << ((K + 1) * CHUNK);

    logic [CHUNK:0]   s;
    logic [WIDTH-1:0] ins;

    assign s = {1'b0, opa_i[K*CHUNK +: CHUNK]}
             + {1'b0, opb_i[K*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, cin};

    // Lower chunks of psum_i are filled, chunk K is still zero.
    assign ins = WIDTH'(s[CHUNK-1:0]) << (K * CHUNK);

    // Stage register: advances only when the pipe is not stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            vout   <= 1'b0;
            cout   <= 1'b0;
            psum_o <= '0;
            opa_o  <= '0;
            opb_o  <= '0;
        end else if (en) begin
            vout   <= vin;
            cout   <= s[CHUNK];
            psum_o <= psum_i | ins;
            opa_o  <= opa_i & KEEP;
            opb_o  <= opb_i & KEEP;
        end
    end

endmodule

// File: rtl/add_pipe.sv
// add_pipe: WIDTH-bit add with STAGES registered carry chunks, valid/ready.
// Define ADD_PIPE_SAT_EN for saturating sum (co still flags overflow).
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    typedef struct packed {
        ctl_t             ctl;
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
    } stage_t;

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad
        $error("add_pipe: STAGES must divide WIDTH exactly");
    end

    stage_t st [STAGES];
    logic   stall;

    // One global stall: the whole pipe freezes while the head waits.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        stage_t din;

        if (k == 0) begin : g_first
            assign din.ctl.valid = in_valid;
            assign din.ctl.carry = ci;
            assign din.psum      = '0;
            assign din.opa       = a;
            assign din.opb       = b;
        end else begin : g_next
            assign din = st[k-1];
        end

        add_pipe_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .K     (k)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en     (~stall),
            .vin    (din.ctl.valid),
            .cin    (din.ctl.carry),
            .psum_i (din.psum),
            .opa_i  (din.opa),
            .opb_i  (din.opb),
            .vout   (st[k].ctl.valid),
            .cout   (st[k].ctl.carry),
            .psum_o (st[k].psum),
            .opa_o  (st[k].opa),
            .opb_o  (st[k].opb)
        );
    end

    assign out_valid = st[STAGES-1].ctl.valid;
    assign co        = st[STAGES-1].ctl.carry;

`ifdef ADD_PIPE_SAT_EN
    assign sum = st[STAGES-1].ctl.carry ? {WIDTH{1'b1}} : st[STAGES-1].psum;
`else
    assign sum = st[STAGES-1].psum;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed tables, hand sequences and random traffic
// against a queue-based arithmetic reference for add_pipe.
module tb_add_pipe;

`ifdef ADD_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, ci, out_valid, out_ready, co;
    logic [15:0] a, b, sum;

    logic        iv8, ir8, ci8, ov8, or8, co8;
    logic [7:0]  a8, b8, s8;

    int n_pass = 0;
    int n_tot  = 0;
    int n_out  = 0;
    logic [16:0] q [$];

    always #5 clk = ~clk;

    add_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .co(co)
    );

    add_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .ci(ci8), .out_valid(ov8),
        .out_ready(or8), .sum(s8), .co(co8)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Reference: exact (WIDTH+1)-bit sum, optional clamp of the low bits.
    function automatic logic [16:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic c);
        logic [16:0] t;
        t = {1'b0, x} + {1'b0, y} + {16'd0, c};
        if (SAT && t[16]) t[15:0] = 16'hFFFF;
        return t;
    endfunction

    // Scoreboard: transfers are decided by signals stable at negedge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                chk("out_has_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0)
                    chk("scoreboard", 32'({co, sum}), 32'(q.pop_front()));
            end
            if (in_valid && in_ready) q.push_back(model(a, b, ci));
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic c);
        bit ok;
        ok = 1'b0;
        a = x; b = y; ci = c; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
    } vec_t;

    vec_t        tbl [9];
    logic [15:0] hist;
    logic        rnd_on;
    int          n0;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, SAT ? 16'hFFFF : 16'h0000, 1'b1};
        tbl[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, SAT ? 16'hFFFF : 16'h0000, 1'b1};
        tbl[4] = '{16'h0FFF, 16'hF000, 1'b1, SAT ? 16'hFFFF : 16'h0000, 1'b1};
        tbl[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
        tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[8] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ci = 1'b0;
        iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0;
        rnd_on = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst8_out_valid", 32'(ov8), 32'd0);
        @(posedge clk); #1;

        // Single transactions: exact latency and value.
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].ci);
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("lat_early", 32'(out_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("lat_valid", 32'(out_valid), 32'd1);
            chk("tbl_sum", 32'(sum), 32'(tbl[i].s));
            chk("tbl_co", 32'(co), 32'(tbl[i].co));
            @(posedge clk); #1;
        end

        // Throughput: 8 back-to-back, expect 8 consecutive outputs.
        hist = '0;
        fork
            begin
                for (int j = 0; j < 16; j++) begin
                    @(negedge clk);
                    hist[j] = out_valid;
                end
            end
            begin
                for (int i = 0; i < 8; i++)
                    send(16'(i), 16'(i * 16'h1000), i[0]);
            end
        join
        chk("throughput_pattern", 32'(hist), 32'h0FF0);
        @(posedge clk); #1;

        // Backpressure: fill the pipe, stall 3 cycles, then release.
        out_ready = 1'b0;
        n0 = n_out;
        for (int i = 0; i < 4; i++)
            send(16'h1111 * 16'(i + 1), 16'h2222, 1'b1);
        a = 16'hABCD; b = 16'h1234; ci = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(sum), 32'(model(16'h1111, 16'h2222, 1'b1)));
            chk("bp_co", 32'(co), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(16'hABCD, 16'h1234, 1'b0);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("bp_delivered", 32'(n_out - n0), 32'd5);

        // Random traffic with random backpressure.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
            send(16'($urandom), 16'($urandom), 1'($urandom));
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("rnd_drain", 32'(q.size()), 32'd0);

        // Reset with three transactions in flight.
        send(16'hAAAA, 16'h5555, 1'b1);
        send(16'h0F0F, 16'h0F0F, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_co", 32'(co), 32'd0);
        n0 = n_out;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_ghost", 32'(n_out - n0), 32'd0);

        // WIDTH=8, STAGES=1: single register, latency 1.
        a8 = 8'h80; b8 = 8'h80; ci8 = 1'b1; iv8 = 1'b1;
        @(negedge clk);
        chk("w8_in_ready", 32'(ir8), 32'd1);
        @(posedge clk);
        #1 iv8 = 1'b0;
        @(negedge clk);
        chk("w8_valid", 32'(ov8), 32'd1);
        chk("w8_sum", 32'(s8), SAT ? 32'h00FF : 32'h0001);
        chk("w8_co", 32'(co8), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("w8_drained", 32'(ov8), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
